// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: op codes (also the result-mux
// select encoding), sequencer state typedef and the divider timeout default.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int unsigned DIV_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DIV,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/calc_div_timer.sv
// Load/increment/expire counter bounding the wait for the divider.
// expired_o is high while the count equals LIMIT-1.
module calc_div_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic inc_i,
  output logic expired_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign expired_o = (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator front-end sequencer: operand capture, divider start/done/timeout
// handshake and held result select. Optional build macro: DIV_ZERO_CHECK_EN.
module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned OP_W        = 4,
  parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [OP_W-1:0] op_a,
  input  logic [OP_W-1:0] op_b,
  input  logic [1:0]      op_code,
  output logic [OP_W-1:0] opnd_a,
  output logic [OP_W-1:0] opnd_b,
  output logic            div_start,
  input  logic            div_done,
  output logic [1:0]      SS,
  output logic            en,
  output logic            res_valid,
  input  logic            res_ack,
  output logic            err
);

`ifdef DIV_ZERO_CHECK_EN
  localparam bit DIV_ZERO_CHECK = 1'b1;
`else
  localparam bit DIV_ZERO_CHECK = 1'b0;
`endif

  state_e          state_q;
  logic [OP_W-1:0] opnd_a_q, opnd_b_q;
  logic [1:0]      ss_q;
  logic            en_q, res_valid_q, err_q, div_start_q;
  logic            tmr_expired;

  calc_div_timer #(
    .LIMIT (DIV_TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (state_q == ST_ISSUE),
    .inc_i     (state_q == ST_WAIT_DIV),
    .expired_o (tmr_expired)
  );

  // div_start is decided on the handshake edge so the pulse lines up with ISSUE;
  // a div in ISSUE without a pending start can only be a rejected divide-by-zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      opnd_a_q    <= '0;
      opnd_b_q    <= '0;
      ss_q        <= OP_ADD;
      en_q        <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (op_valid) begin
            opnd_a_q    <= op_a;
            opnd_b_q    <= op_b;
            ss_q        <= op_code;
            en_q        <= 1'b0;
            err_q       <= 1'b0;
            div_start_q <= (op_code == OP_DIV) && !(DIV_ZERO_CHECK && (op_b == '0));
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ss_q != OP_DIV) begin
            en_q        <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end else if (div_start_q) begin
            state_q <= ST_WAIT_DIV;
          end else begin
            err_q       <= 1'b1;
            en_q        <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_WAIT_DIV: begin
          if (div_done) begin
            err_q       <= 1'b0;
            en_q        <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end else if (tmr_expired) begin
            err_q       <= 1'b1;
            en_q        <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ack) begin
            en_q        <= 1'b0;
            res_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign op_ready  = (state_q == ST_IDLE);
  assign opnd_a    = opnd_a_q;
  assign opnd_b    = opnd_b_q;
  assign div_start = div_start_q;
  assign SS        = ss_q;
  assign en        = en_q;
  assign res_valid = res_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Self-checking bench for calc_op_sequencer: directed cases plus random ops
// checked against a transaction-level latency/err model.
module tb_calc_op_sequencer;

  localparam int unsigned W = 4;
  localparam int T = 16;
  localparam int NEVER = 1000;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [1:0]   op_code = '0;
  logic [W-1:0] opnd_a, opnd_b;
  logic         div_start;
  logic         div_done = 1'b0;
  logic [1:0]   SS;
  logic         en, res_valid;
  logic         res_ack = 1'b0;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  calc_op_sequencer #(.OP_W(W), .DIV_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_code(op_code), .opnd_a(opnd_a), .opnd_b(opnd_b),
    .div_start(div_start), .div_done(div_done), .SS(SS), .en(en),
    .res_valid(res_valid), .res_ack(res_ack), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation. d = cycles from the div_start cycle to the div_done pulse.
  // bp = keep op_valid high with junk operands while busy (and after the ack).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] code,
                        input int d, input int ack_wait, input bit bp);
    int  c, starts, exp_lat, exp_starts;
    bit  exp_err;
    exp_lat = 2; exp_err = 1'b0; exp_starts = 0;
    if (code == 2'b11) begin
      if (ZC && b == '0) begin
        exp_err = 1'b1;
      end else begin
        exp_starts = 1;
        if (d <= T) exp_lat = 2 + d;
        else begin exp_lat = 2 + T; exp_err = 1'b1; end
      end
    end

    check_eq("ready_idle", op_ready, 1'b1);
    op_valid = 1'b1; op_a = a; op_b = b; op_code = code;
    tick();
    if (bp) begin
      op_a = W'($urandom); op_b = W'($urandom); op_code = 2'($urandom);
    end else begin
      op_valid = 1'b0;
    end
    check_eq("ss_capture", SS, code);
    check_eq("en_issue", en, 1'b0);
    check_eq("ready_busy", op_ready, 1'b0);

    c = 1; starts = 0;
    while (!res_valid && c < 40) begin
      check_eq("opnd_a_stable", opnd_a, a);
      check_eq("opnd_b_stable", opnd_b, b);
      starts += int'(div_start);
      div_done = (code == 2'b11) && (c == 1 + d);
      res_ack  = 1'($urandom);
      if (bp) op_a = W'($urandom);
      tick();
      c++;
    end
    div_done = 1'b0;
    res_ack  = 1'b0;
    check_eq("latency", c, exp_lat);
    check_eq("div_start_count", starts, exp_starts);
    check_eq("err_hold", err, exp_err);
    check_eq("en_hold", en, !exp_err);
    check_eq("ss_hold", SS, code);

    for (int i = 0; i < ack_wait; i++) begin
      tick();
      check_eq("res_valid_held", res_valid, 1'b1);
      check_eq("opnd_a_hold", opnd_a, a);
    end
    res_ack = 1'b1;
    if (bp) op_a = W'($urandom);
    tick();
    res_ack = 1'b0;
    check_eq("res_valid_drop", res_valid, 1'b0);
    check_eq("en_drop", en, 1'b0);
    check_eq("ready_after_ack", op_ready, 1'b1);
    check_eq("ss_keep", SS, code);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0]   rc;
    int           rd;

    #2;
    check_eq("rst_ss", SS, 2'b00);
    check_eq("rst_en", en, 1'b0);
    check_eq("rst_valid", res_valid, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_start", div_start, 1'b0);
    check_eq("rst_opnd_a", opnd_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_ready", op_ready, 1'b1);

    run_op(4'h7, 4'h5, 2'b00, 0, 1, 1'b0);
    run_op(4'h9, 4'h3, 2'b11, 4, 0, 1'b0);
    run_op(4'h9, 4'h3, 2'b11, NEVER, 2, 1'b0);
    run_op(4'hA, 4'h2, 2'b11, T, 0, 1'b0);
    run_op(4'hA, 4'h2, 2'b11, T + 1, 0, 1'b0);
    run_op(4'h6, 4'h0, 2'b11, 4, 0, 1'b0);
    run_op(4'h3, 4'hC, 2'b01, 0, 2, 1'b1);
    run_op(4'hE, 4'h1, 2'b10, 0, 0, 1'b0);

    // reset in the middle of a divider wait
    op_valid = 1'b1; op_a = 4'h9; op_b = 4'h3; op_code = 2'b11;
    tick();
    op_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ss", SS, 2'b00);
    check_eq("midrst_en", en, 1'b0);
    check_eq("midrst_valid", res_valid, 1'b0);
    check_eq("midrst_ready", op_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    div_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("late_done_valid", res_valid, 1'b0);
      check_eq("late_done_start", div_start, 1'b0);
      check_eq("late_done_ready", op_ready, 1'b1);
    end
    div_done = 1'b0;
    tick();

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 2'($urandom);
      rd = int'($urandom_range(1, T + 4));
      run_op(ra, rb, rc, rd, int'($urandom_range(0, 3)), (n != 39) && ($urandom_range(0, 3) == 0));
    end
    op_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
